// File: rtl/c2h_pkg.sv
// Shared sizing helpers, keep-mask generation and FSM state type for the
// card-to-host stream packer.
package c2h_pkg;

    // Widest tkeep the mask helper can produce (TDATA_W up to 2048 bits).
    localparam int C2H_MAX_KEEP_W = 256;

    typedef enum logic [0:0] {
        C2H_IDLE = 1'b0,
        C2H_SEND = 1'b1
    } c2h_state_e;

    // Number of address bits needed to index n entries (0 for n<=1).
    function automatic int c2h_clog2(input int n);
        int r;
        int v;
        r = 32'sd0;
        v = 32'sd1;
        for (int i = 0; i < 31; i++) begin
            if (v < n) begin
                v = v * 32'sd2;
                r = r + 32'sd1;
            end
        end
        return r;
    endfunction

    // Counter width for n states, never narrower than one bit.
    function automatic int c2h_idx_w(input int n);
        int w;
        w = c2h_clog2(n);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    function automatic int c2h_ceil_div(input int a, input int b);
        return (a + b - 32'sd1) / b;
    endfunction

    // Beats needed to carry one input word.
    function automatic int c2h_bpw(input int in_w, input int tdata_w);
        return c2h_ceil_div(in_w, tdata_w);
    endfunction

    // Valid bytes on the final slice of a word.
    function automatic int c2h_last_bytes(input int in_w, input int tdata_w);
        return ((in_w - 32'sd1) % tdata_w) / 32'sd8 + 32'sd1;
    endfunction

    // Low nbytes bits set; callers truncate to their tkeep width.
    function automatic logic [C2H_MAX_KEEP_W-1:0] c2h_keep_mask(input int nbytes);
        logic [C2H_MAX_KEEP_W-1:0] m;
        m = '0;
        for (int i = 0; i < C2H_MAX_KEEP_W; i++) begin
            m[i] = (i < nbytes);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_c2h_beat_slicer.sv
// Selects one TDATA_W slice of the held input word, LSB slice first.
// Bits beyond IN_W on the final slice read as zero.
module axis_c2h_beat_slicer
    import c2h_pkg::*;
#(
    parameter int TDATA_W = 512,
    parameter int IN_W    = 4072,
    parameter int BPW     = 8,
    parameter int BEAT_W  = 3
) (
    input  logic [IN_W-1:0]    word,
    input  logic [BEAT_W-1:0]  beat,
    output logic [TDATA_W-1:0] slice,
    output logic               final_slice
);

    localparam int PAD_W = BPW * TDATA_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPW - 1);

    logic [PAD_W-1:0]   padded_s;
    logic [TDATA_W-1:0] slices_s [BPW];

    // Zero-extend the word to a whole number of beats.
    always_comb begin
        padded_s = '0;
        padded_s[IN_W-1:0] = word;
    end

    for (genvar g = 0; g < BPW; g++) begin : g_slice
        assign slices_s[g] = padded_s[g*TDATA_W +: TDATA_W];
    end

    // Beat mux; out-of-range beat indices cannot occur but read as zero.
    always_comb begin
        if (int'(beat) < BPW) begin
            slice = slices_s[beat];
        end else begin
            slice = '0;
        end
    end

    assign final_slice = (beat == LAST_BEAT);

endmodule

// File: rtl/axis_c2h_packer.sv
// Wide-word to AXI4-Stream C2H serializer: slices each input word into
// beats, groups WORDS_PER_PKT words per tlast-terminated packet, trims
// tkeep on the packet's final beat, and supports flush via clr.
module axis_c2h_packer
    import c2h_pkg::*;
#(
    parameter int TDATA_W       = 512,
    parameter int IN_W          = 4072,
    parameter int WORDS_PER_PKT = 1
) (
    input  logic                   m_axis_c2h_aclk,
    input  logic                   m_axis_c2h_areset,
    input  logic                   clr,
    input  logic [IN_W-1:0]        data,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [TDATA_W-1:0]     m_axis_c2h_tdata,
    output logic [TDATA_W/8-1:0]   m_axis_c2h_tkeep,
    output logic                   m_axis_c2h_tlast,
    output logic                   m_axis_c2h_tvalid,
    input  logic                   m_axis_c2h_tready,
    output logic                   busy,
    output logic [31:0]            pkt_count,
    output logic [15:0]            abort_count
);

    localparam int KEEP_W     = TDATA_W / 8;
    localparam int BPW        = c2h_bpw(IN_W, TDATA_W);
    localparam int LAST_BYTES = c2h_last_bytes(IN_W, TDATA_W);
    localparam int BEAT_W     = c2h_idx_w(BPW);
    localparam int WIDX_W     = c2h_idx_w(WORDS_PER_PKT);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPW - 1);
    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS_PER_PKT - 1);
    localparam logic [C2H_MAX_KEEP_W-1:0] KEEP_LAST_FULL = c2h_keep_mask(LAST_BYTES);
    localparam logic [KEEP_W-1:0] KEEP_LAST = KEEP_LAST_FULL[KEEP_W-1:0];
    localparam logic [KEEP_W-1:0] KEEP_ALL  = '1;

    c2h_state_e          state_r;
    logic [IN_W-1:0]     word_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [WIDX_W-1:0]   widx_r;
    logic                tlast_r;
    logic [KEEP_W-1:0]   tkeep_r;
    logic                busy_r;
    logic [31:0]         pkt_count_r;
    logic [15:0]         abort_count_r;

    logic [TDATA_W-1:0]  slice_s;
    logic                final_slice_s;
    logic                tvalid_s;
    logic                data_ready_s;
    logic                accept_s;
    logic                hs_s;
    logic                word_done_s;
    logic                pkt_done_s;
    logic [BEAT_W-1:0]   beat_inc_s;
    logic [WIDX_W-1:0]   widx_next_s;
    logic                first_last_s;
    logic                inc_last_s;

    axis_c2h_beat_slicer #(
        .TDATA_W (TDATA_W),
        .IN_W    (IN_W),
        .BPW     (BPW),
        .BEAT_W  (BEAT_W)
    ) u_slicer (
        .word        (word_r),
        .beat        (beat_r),
        .slice       (slice_s),
        .final_slice (final_slice_s)
    );

    assign tvalid_s     = (state_r == C2H_SEND);
    assign hs_s         = tvalid_s & m_axis_c2h_tready;
    assign word_done_s  = hs_s & final_slice_s;
    assign pkt_done_s   = hs_s & tlast_r;
    // Ready on an empty holder or when the last beat drains this cycle.
    assign data_ready_s = ~clr & (~tvalid_s | (m_axis_c2h_tready & final_slice_s));
    assign accept_s     = data_valid & data_ready_s;

    // Next word index and tlast prediction for the beat about to be presented.
    always_comb begin
        beat_inc_s = beat_r + BEAT_W'(1);
        if (word_done_s) begin
            if (tlast_r) begin
                widx_next_s = '0;
            end else begin
                widx_next_s = widx_r + WIDX_W'(1);
            end
        end else begin
            widx_next_s = widx_r;
        end
        first_last_s = (LAST_BEAT == '0) && (widx_next_s == LAST_WIDX);
        inc_last_s   = (beat_inc_s == LAST_BEAT) && (widx_r == LAST_WIDX);
    end

    // FSM, holding register, beat/word counters and status counters.
    always_ff @(posedge m_axis_c2h_aclk) begin
        if (m_axis_c2h_areset) begin
            state_r       <= C2H_IDLE;
            word_r        <= '0;
            beat_r        <= '0;
            widx_r        <= '0;
            tlast_r       <= 1'b0;
            tkeep_r       <= '0;
            busy_r        <= 1'b0;
            pkt_count_r   <= 32'd0;
            abort_count_r <= 16'd0;
        end else if (clr) begin
            state_r <= C2H_IDLE;
            word_r  <= '0;
            beat_r  <= '0;
            widx_r  <= '0;
            tlast_r <= 1'b0;
            tkeep_r <= '0;
            busy_r  <= 1'b0;
            if (busy_r && (abort_count_r != 16'hFFFF)) begin
                abort_count_r <= abort_count_r + 16'd1;
            end
        end else begin
            widx_r <= widx_next_s;
            if (pkt_done_s) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
            if (accept_s) begin
                // New word; also the zero-bubble path after a final beat.
                word_r  <= data;
                beat_r  <= '0;
                state_r <= C2H_SEND;
                tlast_r <= first_last_s;
                tkeep_r <= first_last_s ? KEEP_LAST : KEEP_ALL;
                busy_r  <= 1'b1;
            end else if (word_done_s) begin
                // Word drained with nothing waiting; word index kept for resume.
                state_r <= C2H_IDLE;
                tlast_r <= 1'b0;
                if (pkt_done_s) begin
                    busy_r <= 1'b0;
                end
            end else if (hs_s) begin
                beat_r  <= beat_inc_s;
                tlast_r <= inc_last_s;
                tkeep_r <= inc_last_s ? KEEP_LAST : KEEP_ALL;
            end
        end
    end

    assign data_ready        = data_ready_s;
    assign m_axis_c2h_tdata  = slice_s;
    assign m_axis_c2h_tkeep  = tkeep_r;
    assign m_axis_c2h_tlast  = tlast_r;
    assign m_axis_c2h_tvalid = tvalid_s;
    assign busy              = busy_r;
    assign pkt_count         = pkt_count_r;
    assign abort_count       = abort_count_r;

endmodule
